// File: rtl/pio_led_sequencer.sv
// LED pattern sequencer: the CPU loads a table and step period, then the block replays the
// table to PIO register 0 over Avalon-MM. Define SEQ_IRQ_EN for the wrap/done interrupt.
module pio_led_sequencer #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned PERIOD_W = 24
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  s_address,
    input  logic        s_chipselect,
    input  logic        s_write_n,
    input  logic [31:0] s_writedata,
    output logic [31:0] s_readdata,
    output logic [1:0]  m_address,
    output logic        m_chipselect,
    output logic        m_write_n,
    output logic [31:0] m_writedata,
    input  logic        m_waitrequest,
    output logic        seq_irq
);
    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StIssue = 2'd1;
    localparam logic [1:0] StHold  = 2'd2;
    localparam logic [3:0] DepthL  = 4'(DEPTH);

    logic [1:0]          state_q, state_d;
    logic                run_q, oneshot_q, done_q;
    logic [PERIOD_W-1:0] period_q;
    logic [3:0]          length_q;
    logic [2:0]          index_q, index_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [DATA_W-1:0]   table_q [DEPTH];

    logic wr, wr_ctrl, wr_period, wr_length, wr_table, table_hit;
    logic at_last, past_last, start, done_set, wrap;
    logic unused_wdata;

    assign wr        = s_chipselect & ~s_write_n;
    assign table_hit = s_address[3] && ({1'b0, s_address[2:0]} < DepthL);
    assign wr_ctrl   = wr && (s_address == 4'd0);
    assign wr_period = wr && (s_address == 4'd1);
    assign wr_length = wr && (s_address == 4'd2);
    assign wr_table  = wr && table_hit;
    assign unused_wdata = ^s_writedata;

    // past_last also covers a LENGTH shrink that left INDEX beyond the new end
    assign at_last   = ({1'b0, index_q} + 4'd1) == length_q;
    assign past_last = ({1'b0, index_q} + 4'd1) >= length_q;
    assign start     = (state_q == StIdle) && run_q;

    always_comb begin
        state_d  = state_q;
        index_d  = index_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        done_set = 1'b0;
        wrap     = 1'b0;
        case (state_q)
            StIdle: begin
                if (run_q) begin
                    state_d = StIssue;
                    index_d = 3'd0;
                    data_d  = table_q[0];
                end
            end
            StIssue: begin
                // never abort a transfer: a cleared RUN only takes effect once accepted
                if (!m_waitrequest) begin
                    if (run_q) begin
                        state_d = StHold;
                        cnt_d   = (period_q == '0) ? '0 : period_q - 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StHold: begin
                if (!run_q) begin
                    state_d = StIdle;
                end else if (cnt_q == '0) begin
                    if (at_last && oneshot_q) begin
                        done_set = 1'b1;
                        state_d  = StIdle;
                    end else begin
                        index_d = past_last ? 3'd0 : index_q + 3'd1;
                        wrap    = at_last;
                        state_d = StIssue;
                        data_d  = table_q[index_d];
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            run_q     <= 1'b0;
            oneshot_q <= 1'b0;
            done_q    <= 1'b0;
            period_q  <= PERIOD_W'(1);
            length_q  <= DepthL;
            index_q   <= 3'd0;
            cnt_q     <= '0;
            data_q    <= '0;
            for (int i = 0; i < int'(DEPTH); i++) table_q[i] <= '0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            if (wr_ctrl) begin
                run_q     <= s_writedata[0];
                oneshot_q <= s_writedata[1];
            end
            if (done_set) run_q <= 1'b0;
            // set beats a simultaneous CPU clear
            if (done_set) done_q <= 1'b1;
            else if (start || (wr_ctrl && s_writedata[3])) done_q <= 1'b0;
            if (wr_period) period_q <= s_writedata[PERIOD_W-1:0];
            if (wr_length) begin
                if (s_writedata[3:0] == 4'd0) length_q <= 4'd1;
                else if (s_writedata[3:0] > DepthL) length_q <= DepthL;
                else length_q <= s_writedata[3:0];
            end
            if (wr_table) table_q[s_address[2:0]] <= s_writedata[DATA_W-1:0];
        end
    end

`ifdef SEQ_IRQ_EN
    logic irq_en_q, irq_pend_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            irq_en_q   <= 1'b0;
            irq_pend_q <= 1'b0;
        end else begin
            if (wr_ctrl) irq_en_q <= s_writedata[4];
            if (wrap || done_set) irq_pend_q <= 1'b1;
            else if (wr_ctrl && s_writedata[5]) irq_pend_q <= 1'b0;
        end
    end

    assign seq_irq = irq_pend_q & irq_en_q;
`else
    logic unused_wrap;
    assign unused_wrap = wrap;
    assign seq_irq     = 1'b0;
`endif

    always_comb begin
        s_readdata = '0;
        if (s_address == 4'd0) begin
            s_readdata[0] = run_q;
            s_readdata[1] = oneshot_q;
            s_readdata[2] = (state_q != StIdle);
            s_readdata[3] = done_q;
`ifdef SEQ_IRQ_EN
            s_readdata[4] = irq_en_q;
            s_readdata[5] = irq_pend_q;
`endif
        end else if (s_address == 4'd1) begin
            s_readdata[PERIOD_W-1:0] = period_q;
        end else if (s_address == 4'd2) begin
            s_readdata[3:0] = length_q;
        end else if (s_address == 4'd3) begin
            s_readdata[2:0] = index_q;
        end else if (table_hit) begin
            s_readdata[DATA_W-1:0] = table_q[s_address[2:0]];
        end
    end

    always_comb begin
        m_writedata             = '0;
        m_writedata[DATA_W-1:0] = data_q;
    end

    assign m_address    = 2'b00;
    assign m_chipselect = (state_q == StIssue);
    assign m_write_n    = ~m_chipselect;

endmodule
